demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter N_OUT, default 4: number of output lanes, legal range 2..8.
REQ-002 Parameter WIDTH, default 32: data width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: input beat present.
REQ-006 Port in_ready, output, 1: block can take the current input beat.
REQ-007 Port in_sel, input, SELW = max(1, $clog2(N_OUT)): destination lane of the input beat.
REQ-008 Port in_data, input, WIDTH: input payload.
REQ-009 Port out_valid, output, N_OUT: per-lane beat present.
REQ-010 Port out_ready, input, N_OUT: per-lane consumer ready.
REQ-011 Port out_data, output, N_OUT x WIDTH: per-lane payload, packed array.
REQ-012 Port drop_err, output, 1: one-cycle pulse; an out-of-range beat was discarded.
REQ-013 Port drop_cnt, output, 8: saturating count of discarded beats.

Function
REQ-014 An input beat SHALL transfer on a rising edge when in_valid && in_ready.
REQ-015 Each lane SHALL hold a 2-entry FIFO; beats leave each lane in arrival order.
REQ-016 in_ready SHALL be combinational from registered state and in_sel only: it is !full[in_sel] when in_sel < N_OUT, and 1 otherwise.
REQ-017 There SHALL be no combinational path from out_ready to in_ready; pushing into a full lane is never permitted, even when that lane pops in the same cycle.
REQ-018 An accepted beat SHALL appear on out_valid/out_data of its lane on the first cycle after acceptance (latency 1), provided the lane was empty.
REQ-019 out_valid[i] SHALL equal (count[i] != 0); out_data[i] SHALL be the lane head; each output SHALL be stable while out_valid[i] && !out_ready[i].
REQ-020 A lane SHALL pop on a rising edge when out_valid[i] && out_ready[i].
REQ-021 Simultaneous push and pop on one lane with count 1 SHALL leave count at 1, with the new head being the pushed beat.
REQ-022 Pushes to one lane SHALL NOT change the count, data or outputs of any other lane.
REQ-023 A transferred beat with in_sel >= N_OUT SHALL be discarded, SHALL assert drop_err for exactly the next cycle, and SHALL increment drop_cnt.
REQ-024 drop_cnt SHALL saturate at 255 and never wrap.
REQ-025 Lane counts SHALL only take the values 0, 1 or 2; a full lane's count SHALL NOT increment.

Reset
REQ-026 While reset_n = 0: all counts, out_valid and drop_err SHALL be 0, drop_cnt SHALL be 0, and out_data SHALL be all zeros.
REQ-027 Asserting reset mid-operation SHALL discard all buffered beats immediately, without waiting for a clock edge.
REQ-028 While reset_n = 0, in_ready SHALL reflect empty lanes, and no input transfer SHALL be counted or stored.

Structure
REQ-029 A shared package demux_pkg SHALL hold the default N_OUT and WIDTH, the SELW function, and the lane-count typedef (2-bit).
REQ-030 The per-lane buffer SHALL be a sub-module lane_fifo2 (push, pop, full, empty, head), instantiated N_OUT times with a generate loop.
REQ-031 Routing to lanes SHALL be a one-hot decode of in_sel gated by the transfer condition, and nothing else.

Verification
REQ-032 Basic route. After reset, drive in_sel=2 with in_data=0xA5A5_0001 while out_ready=4'b1111.
- Response: out_valid=4'b0100 on the next cycle, out_data[2]=0xA5A5_0001; lane is empty one cycle later.
REQ-033 Backpressure. Send 3 beats to lane 1 (0x11, 0x22, 0x33) with out_ready[1]=0.
- Response: the first two beats are accepted; in_ready=0 while the third is presented.
- Then raise out_ready[1]: the lane outputs 0x11, then 0x22, then accepts 0x33.
REQ-034 Push/pop overlap. Lane 0 holds 0x01 and out_ready[0]=1; push 0x02 in that same cycle.
- Response: count stays 1 and out_data[0]=0x02 next.
REQ-035 Lane isolation. Lane 3 is full; send a beat to lane 0.
- Response: the beat to lane 0 is accepted with in_ready=1, and lane 3's state is unchanged.
REQ-036 Out-of-range select. With N_OUT=6, send 300 beats with in_sel=7.
- Response: each beat is accepted and produces a drop_err pulse; drop_cnt ends at 255.
- out_valid stays 0 throughout.
REQ-037 Mid-operation reset. Assert reset_n=0 asynchronously between edges while lanes 0 and 2 hold beats.
- Response: out_valid=0 and drop_cnt=0 before the next clock edge.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer.
//   DEF_N_OUT / DEF_WIDTH : default lane count and payload width
//   lane_cnt_t            : occupancy of one 2-entry lane buffer (0..2)
//   selw()                : width of the lane-select field for a given lane count
package demux_pkg;

    localparam int DEF_N_OUT = 4;
    localparam int DEF_WIDTH = 32;

    typedef logic [1:0] lane_cnt_t;

    function automatic int selw(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/lane_fifo2.sv
// Two-entry FIFO holding the beats queued for one output lane.
//   clk, reset_n : clock, asynchronous active-low reset (clears storage too)
//   push, din    : write din when push and not full
//   pop          : drop the head entry when pop and not empty
//   full, empty  : occupancy flags from registered state
//   head         : oldest entry; held stable until popped
module lane_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    lane_cnt_t        cnt_q;
    lane_cnt_t        cnt_d;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        // Write slot sits one past the head when one entry is held.
        wr_ptr  = rd_ptr_q ^ cnt_q[0];
        cnt_d   = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= din;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Routes a valid/ready input stream to one of N_OUT output lanes, each
// buffered by a 2-entry FIFO. Beats addressed beyond the last lane are
// accepted and discarded, reported by a one-cycle drop_err pulse and a
// saturating 8-bit drop counter.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   in_valid, in_ready            : input handshake
//   in_sel, in_data               : destination lane and payload
//   out_valid, out_ready          : per-lane handshake
//   out_data                      : per-lane head payload (packed array)
//   drop_err, drop_cnt            : discard pulse and saturating count
module demux_stream
    import demux_pkg::*;
#(
    parameter  int N_OUT = DEF_N_OUT,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int SELW  = selw(N_OUT)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SELW-1:0]             in_sel,
    input  logic [WIDTH-1:0]            in_data,
    output logic [N_OUT-1:0]            out_valid,
    input  logic [N_OUT-1:0]            out_ready,
    output logic [N_OUT-1:0][WIDTH-1:0] out_data,
    output logic                        drop_err,
    output logic [7:0]                  drop_cnt
);

    logic [N_OUT-1:0]       push;
    logic [N_OUT-1:0]       full;
    logic [N_OUT-1:0]       empty;
    logic [(1<<SELW)-1:0]   full_ext;
    logic                   xfer;
    logic                   drop_err_q;
    logic                   drop_err_d;
    logic [7:0]             drop_cnt_q;
    logic [7:0]             drop_cnt_d;

    // Unused select codes read as never-full, so out-of-range beats are
    // always accepted. Only registered full flags feed in_ready; a lane
    // popping this cycle cannot open room for a push in the same cycle.
    always_comb begin
        full_ext            = '0;
        full_ext[N_OUT-1:0] = full;
    end

    assign in_ready = !full_ext[in_sel];
    assign xfer     = in_valid && in_ready;

    for (genvar i = 0; i < N_OUT; i++) begin : g_lane
        assign push[i]      = xfer && (in_sel == SELW'(i));
        assign out_valid[i] = !empty[i];

        lane_fifo2 #(
            .WIDTH(WIDTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[i]),
            .pop     (out_valid[i] && out_ready[i]),
            .din     (in_data),
            .full    (full[i]),
            .empty   (empty[i]),
            .head    (out_data[i])
        );
    end

    // A transfer that decoded to no lane is a discard.
    always_comb begin
        drop_err_d = xfer && (push == '0);
        drop_cnt_d = drop_cnt_q;
        if (drop_err_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_err_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            drop_err_q <= drop_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_err = drop_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    // 4-lane instance
    logic               v4;
    logic               rdy4;
    logic [1:0]         sel4;
    logic [31:0]        data4;
    logic [3:0]         ov4;
    logic [3:0]         ordy4;
    logic [3:0][31:0]   od4;
    logic               derr4;
    logic [7:0]         dcnt4;

    // 6-lane instance
    logic               v6;
    logic               rdy6;
    logic [2:0]         sel6;
    logic [31:0]        data6;
    logic [5:0]         ov6;
    logic [5:0]         ordy6;
    logic [5:0][31:0]   od6;
    logic               derr6;
    logic [7:0]         dcnt6;

    demux_stream #(.N_OUT(4), .WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(v4), .in_ready(rdy4), .in_sel(sel4), .in_data(data4),
        .out_valid(ov4), .out_ready(ordy4), .out_data(od4),
        .drop_err(derr4), .drop_cnt(dcnt4)
    );

    demux_stream #(.N_OUT(6), .WIDTH(32)) dut6 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(v6), .in_ready(rdy6), .in_sel(sel6), .in_data(data6),
        .out_valid(ov6), .out_ready(ordy6), .out_data(od6),
        .drop_err(derr6), .drop_cnt(dcnt6)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        int          lane;
        logic [31:0] exp_head;
    } vec_t;

    vec_t vt [18];

    initial begin
        // basic route
        vt[0]  = '{1'b1, 2'd2, 32'hA5A5_0001, 4'b1111, 1'b1, 4'b0100,  2, 32'hA5A5_0001};
        vt[1]  = '{1'b0, 2'd2, 32'h0,         4'b1111, 1'b1, 4'b0000, -1, 32'h0};
        // backpressure on lane 1
        vt[2]  = '{1'b1, 2'd1, 32'h11,        4'b1101, 1'b1, 4'b0010,  1, 32'h11};
        vt[3]  = '{1'b1, 2'd1, 32'h22,        4'b1101, 1'b1, 4'b0010,  1, 32'h11};
        vt[4]  = '{1'b1, 2'd1, 32'h33,        4'b1101, 1'b0, 4'b0010,  1, 32'h11};
        vt[5]  = '{1'b1, 2'd1, 32'h33,        4'b1111, 1'b0, 4'b0010,  1, 32'h22};
        vt[6]  = '{1'b1, 2'd1, 32'h33,        4'b1111, 1'b1, 4'b0010,  1, 32'h33};
        vt[7]  = '{1'b0, 2'd1, 32'h0,         4'b1111, 1'b1, 4'b0000, -1, 32'h0};
        // push/pop overlap on lane 0
        vt[8]  = '{1'b1, 2'd0, 32'h01,        4'b1110, 1'b1, 4'b0001,  0, 32'h01};
        vt[9]  = '{1'b1, 2'd0, 32'h02,        4'b1111, 1'b1, 4'b0001,  0, 32'h02};
        vt[10] = '{1'b0, 2'd0, 32'h0,         4'b1111, 1'b1, 4'b0000, -1, 32'h0};
        // lane isolation: fill lane 3, then push to lane 0
        vt[11] = '{1'b1, 2'd3, 32'hC1,        4'b0111, 1'b1, 4'b1000,  3, 32'hC1};
        vt[12] = '{1'b1, 2'd3, 32'hC2,        4'b0111, 1'b1, 4'b1000,  3, 32'hC1};
        vt[13] = '{1'b1, 2'd3, 32'hC3,        4'b0111, 1'b0, 4'b1000,  3, 32'hC1};
        vt[14] = '{1'b1, 2'd0, 32'hD0,        4'b0110, 1'b1, 4'b1001,  0, 32'hD0};
        vt[15] = '{1'b0, 2'd3, 32'h0,         4'b0110, 1'b0, 4'b1001,  3, 32'hC1};
        vt[16] = '{1'b0, 2'd3, 32'h0,         4'b1111, 1'b0, 4'b1000,  3, 32'hC2};
        vt[17] = '{1'b0, 2'd3, 32'h0,         4'b1111, 1'b1, 4'b0000, -1, 32'h0};

        reset_n = 1'b0;
        v4 = 1'b0; sel4 = '0; data4 = '0; ordy4 = '0;
        v6 = 1'b0; sel6 = '0; data6 = '0; ordy6 = '0;

        // reset state, before any clock edge
        #2;
        chk("rst ov4", 64'(ov4), 64'h0);
        chk("rst od4", 64'(|od4), 64'h0);
        chk("rst derr4", 64'(derr4), 64'h0);
        chk("rst dcnt4", 64'(dcnt4), 64'h0);
        chk("rst rdy4", 64'(rdy4), 64'h1);
        chk("rst ov6", 64'(ov6), 64'h0);

        // an offered beat during reset must not be stored or counted
        v4 = 1'b1; sel4 = 2'd1; data4 = 32'hDEAD;
        v6 = 1'b1; sel6 = 3'd7;
        @(posedge clk); #1;
        chk("rst edge ov4", 64'(ov4), 64'h0);
        chk("rst edge dcnt6", 64'(dcnt6), 64'h0);
        chk("rst edge derr6", 64'(derr6), 64'h0);

        @(negedge clk);
        reset_n = 1'b1;
        v4 = 1'b0; v6 = 1'b0;

        // table-driven vectors on the 4-lane instance
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            v4 = vt[i].vld; sel4 = vt[i].sel; data4 = vt[i].data; ordy4 = vt[i].ordy;
            #1;
            chk($sformatf("row%0d in_ready", i), 64'(rdy4), 64'(vt[i].exp_rdy));
            @(posedge clk); #1;
            chk($sformatf("row%0d out_valid", i), 64'(ov4), 64'(vt[i].exp_ov));
            if (vt[i].lane >= 0) begin
                chk($sformatf("row%0d head%0d", i, vt[i].lane), 64'(od4[vt[i].lane]), 64'(vt[i].exp_head));
            end
            chk($sformatf("row%0d drop_err", i), 64'(derr4), 64'h0);
        end
        @(negedge clk);
        v4 = 1'b0;

        // out-of-range select on the 6-lane instance: 300 discards
        ordy6 = 6'b111111;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            v6 = 1'b1; sel6 = 3'd7; data6 = 32'(k);
            #1;
            chk($sformatf("drop%0d in_ready", k), 64'(rdy6), 64'h1);
            @(posedge clk); #1;
            chk($sformatf("drop%0d drop_err", k), 64'(derr6), 64'h1);
            chk($sformatf("drop%0d out_valid", k), 64'(ov6), 64'h0);
            chk($sformatf("drop%0d drop_cnt", k), 64'(dcnt6), 64'((k > 255) ? 255 : k));
        end
        @(negedge clk);
        v6 = 1'b0;
        @(posedge clk); #1;
        chk("drop idle drop_err", 64'(derr6), 64'h0);
        chk("drop idle drop_cnt", 64'(dcnt6), 64'd255);

        // highest legal lane of the 6-lane instance
        @(negedge clk);
        v6 = 1'b1; sel6 = 3'd5; data6 = 32'h55;
        @(posedge clk); #1;
        chk("lane5 out_valid", 64'(ov6), 64'h20);
        chk("lane5 head", 64'(od6[5]), 64'h55);
        chk("lane5 drop_err", 64'(derr6), 64'h0);
        chk("lane5 drop_cnt", 64'(dcnt6), 64'd255);
        @(negedge clk);
        v6 = 1'b0;

        // mid-operation reset with lanes 0 and 2 holding beats
        ordy4 = 4'b0000;
        @(negedge clk);
        v4 = 1'b1; sel4 = 2'd0; data4 = 32'hE0;
        @(negedge clk);
        data4 = 32'hE1;
        @(negedge clk);
        sel4 = 2'd2; data4 = 32'hE2;
        @(negedge clk);
        sel4 = 2'd0; data4 = 32'hE3;
        #1;
        chk("pre-rst ov4", 64'(ov4), 64'h5);
        chk("pre-rst rdy4", 64'(rdy4), 64'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst ov4", 64'(ov4), 64'h0);
        chk("async rst od4", 64'(|od4), 64'h0);
        chk("async rst rdy4", 64'(rdy4), 64'h1);
        chk("async rst dcnt6", 64'(dcnt6), 64'h0);
        chk("async rst ov6", 64'(ov6), 64'h0);
        @(posedge clk); #1;
        chk("in rst edge ov4", 64'(ov4), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        v4 = 1'b0;
        @(posedge clk); #1;
        chk("post rst ov4", 64'(ov4), 64'h0);
        chk("post rst derr4", 64'(derr4), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
